// File: rtl/change_tx_pkg.sv
// Shared types and helpers for the screen-change request transmitter.
// Used by change_req_tx; the ack handshake variant is selected with CHANGE_TX_ACK_EN.
package change_tx_pkg;

  // Phase of the outgoing stretched pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } tx_state_e;

  // Width of a down-counter able to hold the longer of the two phase lengths.
  function automatic int cnt_width(input int high_cycles, input int low_cycles);
    int longest;
    longest = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/change_req_tx_sync2.sv
// Two-flop synchronizer for a single level crossing into the clk domain.
// Instantiated by change_req_tx only when CHANGE_TX_ACK_EN is defined.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Resample the asynchronous level twice before anyone looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/change_req_tx.sv
// Screen-change transmitter: turns one-cycle req pulses into stretched
// changescr pulses a foreign clock domain can sample, queuing requests that
// arrive while a pulse is in flight.
// Optional macro CHANGE_TX_ACK_EN adds an ack input and makes each phase wait
// for the receiver's acknowledge level (four-phase handshake).
module change_req_tx
  import change_tx_pkg::*;
#(
  parameter int HIGH_CYCLES = 8,
  parameter int LOW_CYCLES  = 8,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              changescr,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
`ifdef CHANGE_TX_ACK_EN
  ,
  input  logic              ack
`endif
);

  localparam int CW = cnt_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]     LOW_LOAD  = CW'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  tx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              changescr_q, changescr_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              high_done;
  logic              low_done;

`ifdef CHANGE_TX_ACK_EN
  logic ack_s;

  sync2 u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack),
    .q     (ack_s)
  );

  // A phase ends only once its minimum length has elapsed and the receiver agrees.
  assign high_done = (cnt_q == '0) && ack_s;
  assign low_done  = (cnt_q == '0) && !ack_s;
`else
  assign high_done = (cnt_q == '0);
  assign low_done  = (cnt_q == '0);
`endif

  // Next-state, phase counter and request queue bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    overflow_d = 1'b0;

    // Counter parks at zero so a handshake can stretch a phase indefinitely.
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req || (pending_q != '0)) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
          // A fresh req alongside a queued one: one enters, one leaves.
          if (!req) begin
            pending_d = pending_q - 1'b1;
          end
        end
      end
      HIGH: begin
        if (high_done) begin
          state_d = LOW;
          cnt_d   = LOW_LOAD;
        end
      end
      LOW: begin
        if (low_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Requests during a pulse are queued; a full queue drops them loudly.
    if ((state_q != IDLE) && req) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end

    changescr_d = (state_d == HIGH);
    busy_d      = (state_d != IDLE) || (pending_d != '0);
  end

  // State and all outputs come straight from flops so changescr cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= '0;
      changescr_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      changescr_q <= changescr_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign changescr = changescr_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_change_req_tx.sv
// Self-checking bench for change_req_tx (default build, no ack handshake).
module tb_change_req_tx;

  localparam int H    = 8;
  localparam int L    = 8;
  localparam int PW   = 3;
  localparam int PMAX = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          changescr;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  always #5 clk = ~clk;

  change_req_tx #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .PEND_W      (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .changescr (changescr),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model in absolute edge time: a pulse started at edge s is high
  // for edges s..s+H-1, low for the next L, and the transmitter is free again
  // from edge s+H+L+1 on.
  int m_t    = 0;
  int m_s    = -1000000;
  int m_pend = 0;
  bit m_ovf  = 1'b0;

  function automatic void model_edge(input bit r);
    m_ovf = 1'b0;
    if (m_t > m_s + H + L) begin
      if (r || (m_pend > 0)) begin
        if (!r) m_pend = m_pend - 1;
        m_s = m_t;
      end
    end else if (r) begin
      if (m_pend < PMAX) m_pend = m_pend + 1;
      else m_ovf = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    m_s    = -1000000;
    m_pend = 0;
    m_ovf  = 1'b0;
  endfunction

  // Scenario statistics.
  int pulses   = 0;
  int ovfs     = 0;
  int max_pend = 0;
  bit prev_cs  = 1'b0;
  int rises[$];

  task automatic clear_stats();
    pulses   = 0;
    ovfs     = 0;
    max_pend = 0;
    rises.delete();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive req, let the edge pass, compare against the model.
  task automatic step(input bit r);
    int exp_cs;
    int exp_busy;
    req = r;
    @(posedge clk);
    #1;
    model_edge(r);
    exp_cs   = ((m_t - m_s) < H) ? 1 : 0;
    exp_busy = (((m_t - m_s) < H + L) || (m_pend != 0)) ? 1 : 0;
    check("model_changescr", int'(changescr), exp_cs);
    check("model_busy", int'(busy), exp_busy);
    check("model_pending", int'(pending), m_pend);
    check("model_overflow", int'(overflow), int'(m_ovf));
    if (changescr && !prev_cs) begin
      pulses++;
      rises.push_back(m_t);
    end
    prev_cs = changescr;
    if (overflow) ovfs++;
    if (int'(pending) > max_pend) max_pend = int'(pending);
    m_t++;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || changescr) && (n < 500)) begin
      step(1'b0);
      n++;
    end
    check("drain_timeout", int'(busy), 0);
  endtask

  // Single request from idle, expectations written out by hand.
  typedef struct {
    bit req;
    bit cs;
    bit busy;
    int pend;
    bit ovf;
  } vec_t;

  vec_t vecs [18] = '{
    '{1'b1, 1'b1, 1'b1, 0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 0, 1'b0},
    '{1'b0, 1'b1, 1'b1, 0, 1'b0},
    '{1'b0, 1'b0, 1'b1, 0, 1'b0},
    '{1'b0, 1'b0, 1'b1, 0, 1'b0},
    '{1'b0, 1'b0, 1'b1, 0, 1'b0},
    '{1'b0, 1'b0, 1'b1, 0, 1'b0},
    '{1'b0, 1'b0, 1'b1, 0, 1'b0},
    '{1'b0, 1'b0, 1'b1, 0, 1'b0},
    '{1'b0, 1'b0, 1'b1, 0, 1'b0},
    '{1'b0, 1'b0, 1'b1, 0, 1'b0},
    '{1'b0, 1'b0, 1'b0, 0, 1'b0},
    '{1'b0, 1'b0, 1'b0, 0, 1'b0}
  };

  task automatic run_table();
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].req);
      check("tbl_changescr", int'(changescr), int'(vecs[i].cs));
      check("tbl_busy", int'(busy), int'(vecs[i].busy));
      check("tbl_pending", int'(pending), vecs[i].pend);
      check("tbl_overflow", int'(overflow), int'(vecs[i].ovf));
    end
  endtask

  initial begin
    int pr;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_changescr", int'(changescr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from idle.
    clear_stats();
    run_table();
    check("single_pulses", pulses, 1);
    $display("single req: pulses=%0d", pulses);

    // Three requests two cycles apart.
    clear_stats();
    step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    drain();
    check("three_pulses", pulses, 3);
    check("three_max_pending", max_pend, 2);
    check("three_final_pending", int'(pending), 0);
    for (int i = 1; i < rises.size(); i++) begin
      check("three_period", rises[i] - rises[i-1], 1 + H + L);
    end
    $display("three reqs: pulses=%0d max_pending=%0d", pulses, max_pend);

    // Request held high for ten cycles: saturation and overflow.
    clear_stats();
    repeat (10) step(1'b1);
    drain();
    check("sat_overflows", ovfs, 2);
    check("sat_pulses", pulses, 8);
    check("sat_max_pending", max_pend, PMAX);
    $display("held req: pulses=%0d overflows=%0d", pulses, ovfs);

    // New request on the idle cycle while three are queued.
    clear_stats();
    repeat (4) step(1'b1);
    repeat (H + L - 3) step(1'b0);
    check("idle_gap_changescr", int'(changescr), 0);
    check("idle_gap_pending", int'(pending), 3);
    step(1'b1);
    check("idle_req_pending", int'(pending), 3);
    check("idle_req_changescr", int'(changescr), 1);
    drain();
    check("idle_req_pulses", pulses, 5);
    $display("idle-cycle req: pulses=%0d", pulses);

    // Reset asserted in the middle of a HIGH phase.
    step(1'b1); step(1'b1); step(1'b1); step(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_changescr", int'(changescr), 0);
    check("async_rst_pending", int'(pending), 0);
    check("async_rst_busy", int'(busy), 0);
    model_reset();
    prev_cs = 1'b0;
    @(posedge clk);
    #1;
    check("held_rst_changescr", int'(changescr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    run_table();
    check("post_rst_pulses", pulses, 1);
    $display("reset mid-pulse: post-reset pulses=%0d", pulses);

    // Randomised traffic with varying request density.
    clear_stats();
    pr = 10;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) == 0) pr = ($urandom_range(0, 2) == 0) ? 3 : (($urandom_range(0, 1) == 0) ? 20 : 70);
      step($urandom_range(0, 99) < pr);
    end
    drain();
    $display("random: pulses=%0d overflows=%0d", pulses, ovfs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_req_tx.md
# change_req_tx

Transmit side of the screen-change crossing. Converts single-cycle `req` pulses from game-control logic into clean, stretched `changescr` level pulses that a slower or unrelated receiver clock can sample reliably with a two-flop synchronizer and rising-edge detector. Requests arriving while a pulse is in flight are counted and replayed in order, so none are lost up to the pending capacity.

## Interface
Parameters:
- `HIGH_CYCLES`, default 8: cycles `changescr` is held high per pulse (≥1).
- `LOW_CYCLES`, default 8: minimum low cycles after each pulse before the next (≥1).
- `PEND_W`, default 3: pending-request counter width; capacity 2^PEND_W−1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  1  one-cycle request pulse; level-high for N cycles = N requests.
- `changescr`  out  1  registered stretched pulse toward receiver.
- `busy`  out  1  high whenever state ≠ IDLE or pending ≠ 0.
- `pending`  out  PEND_W  queued requests not yet transmitted.
- `overflow`  out  1  one-cycle pulse when a request is dropped at saturation.
- `ack`  in  1  receiver acknowledge level (present only with `CHANGE_TX_ACK_EN`).

## Operation
- States: IDLE, HIGH, LOW. Phase counter width = clog2(max(HIGH_CYCLES, LOW_CYCLES)+1).
- IDLE: on `req`, or `pending`>0, go HIGH, load counter. `req` while taking from pending increments and decrements in same cycle → `pending` unchanged.
- HIGH: `changescr`=1; after HIGH_CYCLES cycles go LOW.
- LOW: `changescr`=0; after LOW_CYCLES cycles go IDLE, then start next pulse next cycle if pending.
- `req` in HIGH or LOW: `pending`+1. At 2^PEND_W−1, request dropped, `overflow` pulses, `pending` stays saturated.
- `changescr` driven directly from a flop; never glitches; never high for fewer than HIGH_CYCLES cycles.
- Reset mid-pulse: `changescr` drops immediately (async), queue cleared, state IDLE.

## Timing
- Reset values: `changescr`=0, `busy`=0, `pending`=0, `overflow`=0, state IDLE.
- `req` at edge n in IDLE with empty queue → `changescr` high from edge n+1 through n+HIGH_CYCLES, low from n+HIGH_CYCLES+1.
- Back-to-back period = 1 + HIGH_CYCLES + LOW_CYCLES cycles (one IDLE cycle between pulses).
- `pending`, `busy`, `overflow` registered; update one cycle after causing `req`.

## Configuration
- `CHANGE_TX_ACK_EN` defined: `ack` port exists, passed through a 2-flop synchronizer; HIGH exits only after HIGH_CYCLES elapsed AND synchronized `ack`=1; LOW exits only after LOW_CYCLES elapsed AND synchronized `ack`=0 (full four-phase handshake).
- Undefined: no `ack` port; phases purely count-based as above.

## Structure
- Package `change_tx_pkg`: state enum (IDLE, HIGH, LOW), counter-width function.
- Sub-module `sync2` (two-flop synchronizer with async active-low reset), instantiated only under `CHANGE_TX_ACK_EN`.

## Test plan
- Single `req` from idle, HIGH=8, LOW=8 → `changescr` high exactly 8 cycles starting one cycle after `req`; `busy` clears after 17 cycles total.
- Three `req` pulses 2 cycles apart → `pending` reaches 2, three pulses emitted with 17-cycle period, `pending` returns to 0.
- `req` held high 10 cycles, PEND_W=3 → `pending` saturates at 7, `overflow` pulses twice, 8 pulses total transmitted.
- `req` coinciding with IDLE cycle with pending=3 → `pending` stays 3, new pulse starts.
- `rst_n` low during HIGH phase → `changescr`=0 asynchronously, `pending`=0; post-reset `req` behaves as first scenario.
- With `CHANGE_TX_ACK_EN`, `ack` delayed 20 cycles → `changescr` held high until 2 cycles after `ack` rises; next pulse blocked until `ack` falls.
